// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO result registers for the EX stage.
// Ports: clk, rst (async high); start/op/srcA/srcB launch an op; cancel aborts it;
//   hiWrite/loWrite/writeData implement mthi/mtlo; hiloRead flags mfhi/mflo;
//   hi/lo results; busy while in flight; done pulse on completion; stall to pipeline.
module muldiv_unit #(
    parameter int WIDTH    = 32,
    parameter bit FAST_MUL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic             cancel,
    input  logic             hiWrite,
    input  logic             loWrite,
    input  logic [WIDTH-1:0] writeData,
    input  logic             hiloRead,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, RUN} state_t;
    state_t state, stateNext;

    logic [CW-1:0]    count;
    logic [WIDTH-1:0] acc, shf, opnd;
    logic             isDiv, negLo, negHi, divZero;

    logic accept, last, finish;
    assign accept = (state == IDLE) && start && !cancel;
    assign last   = (state == RUN) && (count == CW'(1));
    assign finish = last && !cancel;

    assign busy  = (state == RUN);
    assign stall = busy && (start || hiWrite || loWrite || hiloRead);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE: if (start && !cancel) stateNext = RUN;
            RUN:  if (cancel || count == CW'(1)) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Operand magnitudes; op[0]=0 selects the signed variants.
    logic             sgnOp, sA, sB;
    logic [WIDTH-1:0] magA, magB;
    assign sgnOp = !op[0];
    assign sA    = sgnOp && srcA[WIDTH-1];
    assign sB    = sgnOp && srcB[WIDTH-1];
    assign magA  = sA ? -srcA : srcA;
    assign magB  = sB ? -srcB : srcB;

    // Shift-add step: {acc,shf} is the partial product, shf holds the
    // unconsumed multiplier bits.
    logic [WIDTH:0]   mulSum;
    logic [WIDTH-1:0] mulAcc, mulShf;
    assign mulSum = {1'b0, acc} + (shf[0] ? {1'b0, opnd} : '0);
    assign mulAcc = mulSum[WIDTH:1];
    assign mulShf = {mulSum[0], shf[WIDTH-1:1]};

    // Restoring divide step: acc is the partial remainder, shf shifts the
    // dividend out at the top and the quotient in at the bottom.
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] divAcc, divShf;
    assign trial  = {acc, shf[WIDTH-1]} - {1'b0, opnd};
    assign divAcc = trial[WIDTH] ? {acc[WIDTH-2:0], shf[WIDTH-1]}
                                 : trial[WIDTH-1:0];
    assign divShf = {shf[WIDTH-2:0], ~trial[WIDTH]};

    logic [WIDTH-1:0] stepAcc, stepShf;
    assign stepAcc = isDiv ? divAcc : mulAcc;
    assign stepShf = isDiv ? divShf : mulShf;

    logic [2*WIDTH-1:0] fastProd, prodSel, prodRes;
    assign fastProd = (2*WIDTH)'(opnd) * (2*WIDTH)'(shf);
    assign prodSel  = FAST_MUL ? fastProd : {stepAcc, stepShf};
    assign prodRes  = negLo ? -prodSel : prodSel;

    // With a zero divisor every trial succeeds, so the remainder ends as
    // the dividend magnitude; only the quotient needs overriding.
    logic [WIDTH-1:0] quo, rem, resHi, resLo;
    assign quo   = negLo ? -stepShf : stepShf;
    assign rem   = negHi ? -stepAcc : stepAcc;
    assign resHi = isDiv ? rem : prodRes[2*WIDTH-1:WIDTH];
    assign resLo = isDiv ? (divZero ? '1 : quo) : prodRes[WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count   <= '0;
            acc     <= '0;
            shf     <= '0;
            opnd    <= '0;
            isDiv   <= 1'b0;
            negLo   <= 1'b0;
            negHi   <= 1'b0;
            divZero <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            done    <= 1'b0;
        end else begin
            done <= finish;
            if (accept) begin
                count   <= (FAST_MUL && !op[1]) ? CW'(1) : CW'(WIDTH);
                acc     <= '0;
                shf     <= op[1] ? magA : magB;
                opnd    <= op[1] ? magB : magA;
                isDiv   <= op[1];
                negLo   <= sA ^ sB;
                negHi   <= sA;
                divZero <= (srcB == '0);
            end else if (state == RUN) begin
                acc   <= stepAcc;
                shf   <= stepShf;
                count <= count - CW'(1);
            end
            if (finish) begin
                hi <= resHi;
                lo <= resLo;
            end else if (state == IDLE) begin
                if (hiWrite) hi <= writeData;
                if (loWrite) lo <= writeData;
            end
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: shift-add and fast-multiply instances.
// Expected HI/LO pairs are queued at launch and popped on each done pulse.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst, start, startF, cancel;
    logic        hiWrite, loWrite, hiloRead;
    logic [1:0]  op;
    logic [31:0] srcA, srcB, writeData;
    logic [31:0] hi, lo, hiF, loF;
    logic        busy, done, stall, busyF, doneF, stallF;

    logic [63:0] expQ[$];
    logic [63:0] expQF[$];
    int passCnt = 0;
    int totalCnt = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(32), .FAST_MUL(1'b0)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .srcA(srcA), .srcB(srcB), .cancel(cancel),
        .hiWrite(hiWrite), .loWrite(loWrite), .writeData(writeData),
        .hiloRead(hiloRead), .hi(hi), .lo(lo),
        .busy(busy), .done(done), .stall(stall)
    );

    muldiv_unit #(.WIDTH(32), .FAST_MUL(1'b1)) dutF (
        .clk(clk), .rst(rst), .start(startF), .op(op),
        .srcA(srcA), .srcB(srcB), .cancel(cancel),
        .hiWrite(hiWrite), .loWrite(loWrite), .writeData(writeData),
        .hiloRead(hiloRead), .hi(hiF), .lo(loF),
        .busy(busyF), .done(doneF), .stall(stallF)
    );

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    always @(negedge clk) begin
        if (!rst && done) begin
            if (expQ.size() == 0) begin
                totalCnt++;
                $display("FAIL spurious_done: got hi/lo %h_%h with none expected",
                         hi, lo);
            end else begin
                check("result", {hi, lo}, expQ.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && doneF) begin
            if (expQF.size() == 0) begin
                totalCnt++;
                $display("FAIL spurious_doneF: got hi/lo %h_%h with none expected",
                         hiF, loF);
            end else begin
                check("resultF", {hiF, loF}, expQF.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    task automatic runOp(input bit fast, input logic [1:0] o,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input int n,
                         input string nm);
        int k;
        op   = o;
        srcA = a;
        srcB = b;
        if (fast) begin
            startF = 1'b1;
            expQF.push_back(exp);
        end else begin
            start = 1'b1;
            expQ.push_back(exp);
        end
        @(negedge clk);
        start  = 1'b0;
        startF = 1'b0;
        srcA   = 32'hA5A5_A5A5;
        srcB   = 32'h5A5A_5A5A;
        k = 0;
        while ((fast ? busyF : busy) && k < 100) begin
            k++;
            @(negedge clk);
        end
        check({nm, "_busy"}, 64'(k), 64'(n));
        @(negedge clk);
        check({nm, "_donepulse"}, {63'b0, (fast ? doneF : done)}, 64'd0);
    endtask

    initial begin
        int s;
        int k;
        rst = 1'b1; start = 1'b0; startF = 1'b0; cancel = 1'b0;
        hiWrite = 1'b0; loWrite = 1'b0; hiloRead = 1'b0;
        op = 2'b00; srcA = '0; srcB = '0; writeData = '0;
        @(negedge clk);
        @(negedge clk);
        check("reset_hilo", {hi, lo}, 64'd0);
        check("reset_flags", {62'b0, busy, done}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        runOp(0, 2'b00, 32'd7, 32'hFFFF_FFFD, 64'hFFFFFFFF_FFFFFFEB, 32, "mult");
        runOp(0, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
              64'hFFFFFFFE_00000001, 32, "multu");
        runOp(1, 2'b00, 32'd7, 32'hFFFF_FFFD, 64'hFFFFFFFF_FFFFFFEB, 1, "fmult");
        runOp(1, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
              64'hFFFFFFFE_00000001, 1, "fmultu");
        runOp(0, 2'b10, 32'hFFFF_FFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 32, "div");
        runOp(0, 2'b11, 32'd7, 32'd0, 64'h00000007_FFFFFFFF, 32, "divu0");
        runOp(0, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF,
              64'h00000000_80000000, 32, "divovf");
        runOp(0, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF,
              64'h80000000_00000000, 32, "divubig");

        hiWrite = 1'b1; writeData = 32'd5;
        @(negedge clk);
        hiWrite = 1'b0; loWrite = 1'b1; writeData = 32'd6;
        @(negedge clk);
        loWrite = 1'b0;
        check("mthi_mtlo", {hi, lo}, 64'h00000005_00000006);

        op = 2'b10; srcA = 32'd100; srcB = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check("cancel_busy", {63'b0, busy}, 64'd0);
        check("cancel_done", {63'b0, done}, 64'd0);
        @(negedge clk);
        check("cancel_hilo", {hi, lo}, 64'h00000005_00000006);

        runOp(0, 2'b11, 32'd9, 32'd4, 64'h00000001_00000002, 32, "divu94");

        op = 2'b10; srcA = 32'd20; srcB = 32'd3; start = 1'b1;
        expQ.push_back(64'h00000002_00000006);
        @(negedge clk);
        hiloRead = 1'b1; hiWrite = 1'b1; writeData = 32'hDEAD_BEEF;
        s = 0;
        k = 0;
        while (busy && k < 100) begin
            if (stall) s++;
            k++;
            @(negedge clk);
        end
        check("stall_busy_cycles", 64'(s), 64'd32);
        check("stall_done_cycle", {63'b0, stall}, 64'd0);
        start = 1'b0; hiloRead = 1'b0; hiWrite = 1'b0;
        @(negedge clk);
        check("stall_hi_kept", {32'b0, hi}, 64'd2);

        op = 2'b01; srcA = 32'd3; srcB = 32'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_busy", {63'b0, busy}, 64'd0);
        check("rst_mid_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("queue_drain", 64'(expQ.size() + expQF.size()), 64'd0);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end
endmodule
